dta_egr_snd_protocol_error_collector: RTL and testbench

Consumes the per-cycle `protocol_error` / `protocol_error_ap_vld` stream of the egress-send protocol monitor and turns it into software-visible status. Outputs are sticky error bits with per-bit mask and write-1-to-clear, a first-error snapshot, a saturating event counter and a level interrupt. It sits directly downstream of the monitor, between it and the control-register block.

---
 rtl/dta_egr_snd_protocol_error_collector.sv | 128 ++++++++++++
 tb/tb_dta_egr_snd_protocol_error_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dta_egr_snd_protocol_error_collector.sv
// Egress-send protocol error collector: sticky bits, first capture, counter, irq.
// Optional first-event timestamp enabled by DTA_ERR_TIMESTAMP_EN.
module dta_egr_snd_protocol_error_collector #(
  parameter int CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [15:0]      protocol_error,
  input  logic             protocol_error_ap_vld,
  input  logic [15:0]      err_mask,
  input  logic [15:0]      irq_en,
  input  logic             clear_vld,
  input  logic [15:0]      clear_bits,
  input  logic             count_clear,
  output logic [15:0]      err_sticky,
  output logic [15:0]      err_first,
  output logic             err_first_vld,
  output logic [CNT_W-1:0] err_count,
  output logic             err_irq,
  output logic [31:0]      err_first_ts
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state_q;
  logic [15:0]      sticky_q, sticky_d;
  logic [15:0]      first_q;
  logic             first_vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q;
  logic [15:0]      ev_bits;
  logic             ev;
  logic             cap;
  logic             rearm;

  always_comb begin
    ev_bits = '0;
    if (protocol_error_ap_vld) begin
      ev_bits = protocol_error & ~err_mask;
    end
    ev = |ev_bits;
    sticky_d = sticky_q;
    if (clear_vld) begin
      sticky_d = sticky_q & ~clear_bits;
    end
    sticky_d = sticky_d | ev_bits;
    // A same-cycle clear and event leaves the counter at one.
    cnt_d = cnt_q;
    if (count_clear) begin
      cnt_d = ev ? CNT_W'(1) : '0;
    end else if (ev && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cap   = (state_q == IDLE) && ev;
  assign rearm = (state_q == HELD) && (sticky_d == '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      sticky_q    <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      irq_q    <= |(sticky_d & irq_en);
      unique case (state_q)
        IDLE: begin
          if (ev) begin
            state_q     <= HELD;
            first_q     <= ev_bits;
            first_vld_q <= 1'b1;
          end
        end
        HELD: begin
          if (sticky_d == '0) begin
            state_q     <= IDLE;
            first_q     <= '0;
            first_vld_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          first_vld_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DTA_ERR_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] first_ts_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts_q       <= '0;
      first_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (cap) begin
        first_ts_q <= ts_q;
      end else if (rearm) begin
        first_ts_q <= '0;
      end
    end
  end

  assign err_first_ts = first_ts_q;
`else
  logic unused_ts;
  assign unused_ts    = cap ^ rearm;
  assign err_first_ts = '0;
`endif

  assign err_sticky    = sticky_q;
  assign err_first     = first_q;
  assign err_first_vld = first_vld_q;
  assign err_count     = cnt_q;
  assign err_irq       = irq_q;

endmodule

// File: tb/tb_dta_egr_snd_protocol_error_collector.sv
// Randomized bench for the protocol error collector against a cycle model.
// Timestamp expectations follow DTA_ERR_TIMESTAMP_EN.
module tb_dta_egr_snd_protocol_error_collector;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [15:0]   pe, mask, ien, cbits;
  logic          vld, cvld, cclr;
  logic [15:0]   sticky, first;
  logic          fvld, irq;
  logic [CW-1:0] cnt;
  logic [31:0]   fts;

  int nvec;
  int nbad;

  logic [15:0] st_m, first_m;
  bit          held_m;
  int          cnt_m;
  bit          irq_m;
  logic [31:0] ts_m, fts_m;

  dta_egr_snd_protocol_error_collector #(.CNT_W(CW)) dut (
    .ap_clk                (clk),
    .ap_rst_n              (rst_n),
    .protocol_error        (pe),
    .protocol_error_ap_vld (vld),
    .err_mask              (mask),
    .irq_en                (ien),
    .clear_vld             (cvld),
    .clear_bits            (cbits),
    .count_clear           (cclr),
    .err_sticky            (sticky),
    .err_first             (first),
    .err_first_vld         (fvld),
    .err_count             (cnt),
    .err_irq               (irq),
    .err_first_ts          (fts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    st_m    = '0;
    first_m = '0;
    held_m  = 1'b0;
    cnt_m   = 0;
    irq_m   = 1'b0;
    ts_m    = '0;
    fts_m   = '0;
  endtask

  task automatic model_tick();
    logic [15:0] ev;
    logic [15:0] nxt;
    ev  = vld ? (pe & ~mask) : 16'h0;
    nxt = cvld ? (st_m & ~cbits) : st_m;
    nxt = nxt | ev;
    if (cclr) cnt_m = (ev != 0) ? 1 : 0;
    else if (ev != 0 && cnt_m < MAXC) cnt_m = cnt_m + 1;
    if (!held_m && ev != 0) begin
      held_m  = 1'b1;
      first_m = ev;
`ifdef DTA_ERR_TIMESTAMP_EN
      fts_m = ts_m;
`endif
    end else if (held_m && nxt == 0) begin
      held_m  = 1'b0;
      first_m = '0;
      fts_m   = '0;
    end
    st_m  = nxt;
    irq_m = (nxt & ien) != 0;
    ts_m  = ts_m + 32'd1;
  endtask

  task automatic cmp_all();
    chk("sticky", 32'(sticky), 32'(st_m));
    chk("first", 32'(first), 32'(first_m));
    chk("first_vld", 32'(fvld), 32'(held_m));
    chk("count", 32'(cnt), 32'(cnt_m));
    chk("irq", 32'(irq), 32'(irq_m));
    chk("first_ts", fts, fts_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    pe = '0; vld = 0; cvld = 0; cbits = '0; cclr = 0; mask = '0;
  endtask

  // Asynchronous reset asserted mid-cycle, released well before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    model_clear();
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_count", 32'(cnt), 32'h0);
    chk("rst_fvld", 32'(fvld), 32'h0);
    chk("rst_first", 32'(first), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ts", fts, 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    ien  = '0;
    idle_inputs();
    model_clear();
    rst_n = 1'b0;
    #12;
    do_reset();

    // Basic capture with interrupt.
    ien = 16'h0001;
    pe = 16'h0041; vld = 1;
    step();
    vld = 0;
    chk("t1_sticky", 32'(sticky), 32'h41);
    chk("t1_first", 32'(first), 32'h41);
    chk("t1_fvld", 32'(fvld), 32'h1);
    chk("t1_count", 32'(cnt), 32'h1);
    chk("t1_irq", 32'(irq), 32'h1);

    // Masked and unqualified inputs are ignored.
    do_reset();
    mask = 16'h0040; pe = 16'h0040; vld = 1;
    step();
    chk("t2_sticky", 32'(sticky), 32'h0);
    chk("t2_count", 32'(cnt), 32'h0);
    chk("t2_fvld", 32'(fvld), 32'h0);
    pe = 16'h0200; vld = 0;
    step();
    chk("t2_novld", 32'(sticky), 32'h0);

    // First capture held across later events and partial clears.
    mask = 0; pe = 16'h0001; vld = 1;
    step();
    pe = 16'h2000;
    step();
    vld = 0;
    chk("t3_sticky", 32'(sticky), 32'h2001);
    chk("t3_first", 32'(first), 32'h0001);
    cvld = 1; cbits = 16'h0001;
    step();
    chk("t3_held", 32'(fvld), 32'h1);
    cbits = 16'h2000;
    step();
    cvld = 0;
    chk("t3_rearm", 32'(fvld), 32'h0);
    chk("t3_first0", 32'(first), 32'h0);

    // Set beats clear; count clear with event gives one.
    cvld = 1; cbits = 16'h0008; pe = 16'h0008; vld = 1;
    step();
    cvld = 0;
    chk("t4_setwins", 32'(sticky[3]), 32'h1);
    cclr = 1;
    step();
    cclr = 0; vld = 0;
    chk("t4_cclr", 32'(cnt), 32'h1);

    // Counter saturation.
    pe = 16'h0001; vld = 1;
    for (int i = 0; i < 300; i++) step();
    chk("t5_sat", 32'(cnt), 32'(MAXC));
    step();
    vld = 0;
    step();
    chk("t5_hold", 32'(cnt), 32'(MAXC));

    // First-event timestamp.
    do_reset();
    for (int i = 0; i < 100; i++) step();
    pe = 16'h0004; vld = 1;
    step();
    vld = 0;
`ifdef DTA_ERR_TIMESTAMP_EN
    chk("t6_ts", fts, 32'd100);
`else
    chk("t6_ts", fts, 32'd0);
`endif
    for (int i = 0; i < 49; i++) step();
    pe = 16'h0010; vld = 1;
    step();
    vld = 0;
`ifdef DTA_ERR_TIMESTAMP_EN
    chk("t6_ts2", fts, 32'd100);
`else
    chk("t6_ts2", fts, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      vld   = ($urandom_range(0, 2) == 0);
      pe    = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cvld  = ($urandom_range(0, 4) == 0);
      cbits = ($urandom_range(0, 1) == 0) ? 16'hffff : 16'($urandom);
      cclr  = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 40) == 0)
        mask = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 50) == 0)
        ien = 16'($urandom);
      step();
      if ($urandom_range(0, 400) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
